alu_issuer: RTL and testbench
=============================

Name: alu_issuer

Overview:
Sequential initiator that feeds the combinational ALU. It accepts one command per valid/ready handshake, registers the opcode and operands onto the ALU input bus, and waits a programmable settle time. It then captures y and the c_out/v/n/z flags into a persistent NZCV flag register and returns the result on a valid/ready response channel. It also supplies c_in from the stored carry, so multi-word add/sub chains run without external glue.

Parameters:
W, 4, width of opcode, operands and result (matches the ALU's W).
SETTLE_CYCLES, 1, cycles the ALU inputs are held before capture; must be >=1, and 0 is an elaboration error.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command; high only in IDLE.
cmd_opcode  input  W  operation, encoded per the alu_ops package.
cmd_a  input  W  operand a.
cmd_b  input  W  operand b.
cmd_use_carry  input  1  1: c_in comes from the stored carry flag; 0: c_in is 0.
flag_clr  input  1  synchronous pulse that clears the flag register.
alu_opcode  output  W  to ALU opcode.
alu_a  output  W  to ALU a.
alu_b  output  W  to ALU b.
alu_c_in  output  1  to ALU c_in.
alu_y  input  W  from ALU y.
alu_c_out  input  1  from ALU c_out.
alu_v  input  1  from ALU v.
alu_n  input  1  from ALU n.
alu_z  input  1  from ALU z.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer accepts the result.
rsp_y  output  W  captured result.
rsp_flags  output  4  captured {n,z,c,v}.
flags  output  4  current flag register {n,z,c,v}.
busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, settle counter=0. The following outputs are 0: rsp_valid, rsp_y, rsp_flags, flags, alu_opcode, alu_a, alu_b, alu_c_in, busy.
- A reset mid-EXEC or mid-RESP drops the operation silently; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at an edge: alu_opcode/alu_a/alu_b <= cmd fields; alu_c_in <= cmd_use_carry ? flags.c : 0; counter <= SETTLE_CYCLES-1; go to EXEC.
- EXEC:
  - cmd_ready=0. ALU inputs held stable.
  - Counter decrements each cycle. At the edge where the counter is 0:
    - rsp_y <= alu_y;
    - rsp_flags <= {alu_n, alu_z, alu_c_out, alu_v};
    - flag register <= the same value;
    - go to RESP.
- RESP:
  - rsp_valid=1. rsp_y and rsp_flags stay stable until rsp_ready.
  - On rsp_ready at an edge: go to IDLE. cmd_ready rises the following cycle; there is no accept in the same cycle.
- Timing:
  - Command handshake at edge k: rsp_valid is high after edge k+SETTLE_CYCLES.
  - Maximum throughput is one command per SETTLE_CYCLES+2 cycles.
- ALU inputs keep their last values after an operation completes and change only on the next accept.
- flag_clr:
  - In any state, clears the flag register at the next edge.
  - If it coincides with the EXEC capture edge, the capture wins.
  - A flag_clr in the same edge as a cmd accept clears after c_in is sampled; the accepted command uses the old carry.
- cmd_valid asserted outside IDLE is ignored (not accepted). The sender must hold the command until cmd_ready.

Optional Feature:
ALU_CTRL_ILLEGAL_OP_EN
- Defined:
  - Adds output rsp_err (1 bit, resets to 0).
  - Accepting an opcode outside the ten alu_ops values (LL_SHIFT, LR_SHIFT, AL_SHIFT, AR_SHIFT, NOT, AND, OR, XOR, ADD, SUB) leaves the alu_* outputs unchanged and skips EXEC, going directly to RESP at the next edge.
  - That response has rsp_y=0, rsp_flags=0 and rsp_err=1; the flag register is unchanged.
  - Legal opcodes give rsp_err=0.
- Undefined: no rsp_err port; every opcode is forwarded and executed.

Test Plan:
- Reset mid-operation: assert rst during EXEC -> rsp_valid=0, flags=0, all alu_* outputs=0 immediately; cmd_ready=1 after release; no stale response appears.
- Single ADD (W=4, SETTLE_CYCLES=1, bench ALU model with true 4-bit carry/overflow): a=4'h7, b=4'h1, use_carry=0 -> alu_c_in=0; rsp_valid one cycle after accept; rsp_y=4'h8, rsp_flags n=1 z=0 c=0 v=1.
- Carry chain:
  - ADD 4'hF+4'h1 -> y=0, flags c=1 z=1.
  - Next, ADD a=0, b=0, use_carry=1 -> alu_c_in=1, rsp_y=4'h1, c=0.
  - flag_clr, then repeat with use_carry=1 -> alu_c_in=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_y/rsp_flags stable, cmd_ready=0, a concurrent cmd_valid is not accepted; rsp_ready=1 -> IDLE, cmd_ready=1 the next cycle.
- Settle: SETTLE_CYCLES=3, AND a=4'hC, b=4'hA -> alu inputs stable 3 cycles; rsp_valid exactly 3 cycles after accept; rsp_y=4'h8.
- With ALU_CTRL_ILLEGAL_OP_EN: an opcode value not in alu_ops -> rsp_valid the next cycle, rsp_err=1, rsp_y=0, flags and alu_* outputs unchanged; a following legal op -> rsp_err=0.

Source files
------------

// File: rtl/alu_issuer.sv
// Sequential command issuer for the combinational ALU: registers operands, waits a settle time,
// captures result and NZCV flags. Optional macro ALU_CTRL_ILLEGAL_OP_EN adds rsp_err and illegal-op bypass.
module alu_issuer #(
  parameter int unsigned W             = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_opcode,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_carry,
  input  logic         flag_clr,
  output logic [W-1:0] alu_opcode,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_c_in,
  input  logic [W-1:0] alu_y,
  input  logic         alu_c_out,
  input  logic         alu_v,
  input  logic         alu_n,
  input  logic         alu_z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_y,
  output logic [3:0]   rsp_flags,
  output logic [3:0]   flags,
  output logic         busy
`ifdef ALU_CTRL_ILLEGAL_OP_EN
  ,
  output logic         rsp_err
`endif
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_issuer: SETTLE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    op_q, op_d, a_q, a_d, b_q, b_d, y_q, y_d;
  logic            cin_q, cin_d;
  logic [3:0]      rsp_flags_q, rsp_flags_d, flags_q, flags_d;
  logic            legal;

`ifdef ALU_CTRL_ILLEGAL_OP_EN
  localparam int unsigned NumOps = 10;
  logic err_q, err_d;
  assign legal   = (32'(cmd_opcode) < NumOps);
  assign rsp_err = err_q;
`else
  assign legal = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    y_d         = y_q;
    rsp_flags_d = rsp_flags_q;
    flags_d     = flags_q;
`ifdef ALU_CTRL_ILLEGAL_OP_EN
    err_d       = err_q;
`endif
    // A clear is overridden below by an EXEC capture on the same edge.
    if (flag_clr) flags_d = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (legal) begin
            op_d    = cmd_opcode;
            a_d     = cmd_a;
            b_d     = cmd_b;
            cin_d   = cmd_use_carry & flags_q[1];
            cnt_d   = CntInit;
            state_d = StExec;
          end else begin
            y_d         = '0;
            rsp_flags_d = '0;
`ifdef ALU_CTRL_ILLEGAL_OP_EN
            err_d       = 1'b1;
`endif
            state_d     = StResp;
          end
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          y_d         = alu_y;
          rsp_flags_d = {alu_n, alu_z, alu_c_out, alu_v};
          flags_d     = {alu_n, alu_z, alu_c_out, alu_v};
`ifdef ALU_CTRL_ILLEGAL_OP_EN
          err_d       = 1'b0;
`endif
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      y_q         <= '0;
      rsp_flags_q <= '0;
      flags_q     <= '0;
`ifdef ALU_CTRL_ILLEGAL_OP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      y_q         <= y_d;
      rsp_flags_q <= rsp_flags_d;
      flags_q     <= flags_d;
`ifdef ALU_CTRL_ILLEGAL_OP_EN
      err_q       <= err_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_c_in   = cin_q;
  assign rsp_y      = y_q;
  assign rsp_flags  = rsp_flags_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: table-driven ops with a scoreboard, plus hand-written
// sequences for flag_clr, backpressure, reset mid-op, settle time and (optionally) illegal opcodes.
module tb_alu_issuer;
  localparam int unsigned W = 4;
  localparam logic [3:0] OpNot = 4'd4, OpAnd = 4'd5, OpOr = 4'd6, OpXor = 4'd7;
  localparam logic [3:0] OpAdd = 4'd8, OpSub = 4'd9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         cmd_valid, cmd_ready, cmd_use_carry, flag_clr, alu_c_in;
  logic [W-1:0] cmd_opcode, cmd_a, cmd_b, alu_opcode, alu_a, alu_b, alu_y, rsp_y;
  logic         alu_c_out, alu_v, alu_n, alu_z, rsp_valid, rsp_ready, busy, rsp_err;
  logic [3:0]   rsp_flags, flags;

  logic         cmd_valid3, cmd_ready3, alu_c_in3, alu_c_out3, alu_v3, alu_n3, alu_z3;
  logic [W-1:0] alu_opcode3, alu_a3, alu_b3, alu_y3, rsp_y3;
  logic         rsp_valid3, rsp_ready3, busy3, rsp_err3;
  logic [3:0]   rsp_flags3, flags3;

  alu_issuer #(.W(W), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_carry(cmd_use_carry),
    .flag_clr(flag_clr), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c_in(alu_c_in), .alu_y(alu_y), .alu_c_out(alu_c_out), .alu_v(alu_v), .alu_n(alu_n),
    .alu_z(alu_z), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .flags(flags), .busy(busy)
`ifdef ALU_CTRL_ILLEGAL_OP_EN
    , .rsp_err(rsp_err)
`endif
  );

  alu_issuer #(.W(W), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_carry(cmd_use_carry),
    .flag_clr(1'b0), .alu_opcode(alu_opcode3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_c_in(alu_c_in3), .alu_y(alu_y3), .alu_c_out(alu_c_out3), .alu_v(alu_v3),
    .alu_n(alu_n3), .alu_z(alu_z3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_y(rsp_y3), .rsp_flags(rsp_flags3), .flags(flags3), .busy(busy3)
`ifdef ALU_CTRL_ILLEGAL_OP_EN
    , .rsp_err(rsp_err3)
`endif
  );

`ifndef ALU_CTRL_ILLEGAL_OP_EN
  assign rsp_err  = 1'b0;
  assign rsp_err3 = 1'b0;
`endif

  // Reference ALU: returns {y, n, z, c, v} with true 4-bit carry and overflow.
  function automatic logic [7:0] alu_model(input logic [3:0] op, a, b, input logic cin);
    logic [4:0] r;
    logic       v;
    r = '0;
    v = 1'b0;
    case (op)
      4'd0:  r[3:0] = a << b[1:0];
      4'd1:  r[3:0] = a >> b[1:0];
      4'd2:  r[3:0] = a << b[1:0];
      4'd3:  r[3:0] = 4'($signed(a) >>> b[1:0]);
      OpNot: r[3:0] = ~a;
      OpAnd: r[3:0] = a & b;
      OpOr:  r[3:0] = a | b;
      OpXor: r[3:0] = a ^ b;
      OpAdd: begin
        r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      OpSub: begin
        r = {1'b0, a} - {1'b0, b} - {4'b0, cin};
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      default: r = '0;
    endcase
    return {r[3:0], r[3], (r[3:0] == 4'd0), r[4], v};
  endfunction

  always_comb {alu_y, alu_n, alu_z, alu_c_out, alu_v} = alu_model(alu_opcode, alu_a, alu_b, alu_c_in);
  always_comb {alu_y3, alu_n3, alu_z3, alu_c_out3, alu_v3} =
      alu_model(alu_opcode3, alu_a3, alu_b3, alu_c_in3);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [3:0] y; logic [3:0] fl; logic err;} exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] op, a, b;
    logic       uc, cin;
    logic [3:0] y, fl;
  } vec_t;
  vec_t vecs[8];

  // Drive one command into u_dut, push its expectation, check c_in/operand on the next negedge.
  task automatic issue(input logic [3:0] op, a, b, input logic uc, input logic exp_cin,
                       input logic [3:0] ey, efl, input logic clr);
    int n;
    @(negedge clk);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_use_carry = uc; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    flag_clr = clr;
    sb.push_back('{y: ey, fl: efl, err: 1'b0});
    @(posedge clk);
    #1 cmd_valid = 1'b0; flag_clr = 1'b0;
    @(negedge clk);
    check("alu_c_in", alu_c_in, exp_cin);
    check("alu_a", alu_a, a);
  endtask

  // Accept a response from u_dut and compare against the scoreboard head.
  task automatic collect(input int exp_lat);
    int   n;
    exp_t e;
    rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", n, exp_lat);
    check("sb_nonempty", (sb.size() > 0), 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check("rsp_y", rsp_y, e.y);
    check("rsp_flags", rsp_flags, e.fl);
    check("flags", flags, e.fl);
`ifdef ALU_CTRL_ILLEGAL_OP_EN
    check("rsp_err", rsp_err, e.err);
`endif
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    cmd_valid = 0; cmd_opcode = 0; cmd_a = 0; cmd_b = 0; cmd_use_carry = 0;
    flag_clr = 0; rsp_ready = 0; cmd_valid3 = 0; rsp_ready3 = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_flags", flags, 0);
    check("rst_rsp_y", {rsp_y, rsp_flags}, 0);
    check("rst_alu_in", {alu_opcode, alu_a, alu_b, alu_c_in}, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_err", rsp_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{OpAdd, 4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 4'b1001};
    vecs[1] = '{OpAdd, 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 4'b0110};
    vecs[2] = '{OpAdd, 4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 4'b0000};
    vecs[3] = '{OpAnd, 4'hC, 4'hA, 1'b0, 1'b0, 4'h8, 4'b1000};
    vecs[4] = '{OpXor, 4'h5, 4'h5, 1'b0, 1'b0, 4'h0, 4'b0100};
    vecs[5] = '{OpSub, 4'h3, 4'h5, 1'b0, 1'b0, 4'hE, 4'b1010};
    vecs[6] = '{OpAdd, 4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 4'b0000};
    vecs[7] = '{OpOr,  4'h9, 4'h6, 1'b0, 1'b0, 4'hF, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].uc, vecs[i].cin, vecs[i].y, vecs[i].fl, 1'b0);
      collect(1);
    end

    // flag_clr drops the stored carry
    issue(OpAdd, 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 4'b0110, 1'b0);
    collect(1);
    @(negedge clk) flag_clr = 1'b1;
    @(negedge clk) flag_clr = 1'b0;
    check("flag_clr_flags", flags, 0);
    issue(OpAdd, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'b0100, 1'b0);
    collect(1);

    // flag_clr on the accept edge: command still sees the old carry
    issue(OpAdd, 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 4'b0110, 1'b0);
    collect(1);
    issue(OpAdd, 4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 4'b0000, 1'b1);
    check("flags_clr_at_accept", flags, 0);
    collect(1);

    // flag_clr on the capture edge: capture wins
    issue(OpAdd, 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 4'b0110, 1'b0);
    flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    collect(0);

    // Backpressure with a concurrent command
    issue(OpAnd, 4'hC, 4'hA, 1'b0, 1'b0, 4'h8, 4'b1000, 1'b0);
    @(negedge clk);
    check("bp_rsp_valid", rsp_valid, 1);
    e = sb.pop_front();
    cmd_opcode = OpXor; cmd_a = 4'h3; cmd_b = 4'h5; cmd_use_carry = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_y", rsp_y, e.y);
      check("bp_hold_flags", rsp_flags, e.fl);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_no_accept", alu_a, 4'hC);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_ready", cmd_ready, 1);
    check("bp_no_same_cycle", alu_a, 4'hC);
    check("bp_busy", busy, 0);
    sb.push_back('{y: 4'h6, fl: 4'b0000, err: 1'b0});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_next_accept", alu_a, 4'h3);
    collect(1);

    // Reset during EXEC drops the operation
    issue(OpAdd, 4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 4'b1001, 1'b0);
    void'(sb.pop_back());
    check("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_flags", flags, 0);
    check("mid_rst_alu", {alu_opcode, alu_a, alu_b, alu_c_in}, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    check("post_rst_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    // Settle time of 3 cycles on the second instance
    @(negedge clk);
    cmd_opcode = OpAnd; cmd_a = 4'hC; cmd_b = 4'hA; cmd_use_carry = 1'b0; cmd_valid3 = 1'b1;
    check("s3_ready", cmd_ready3, 1);
    @(posedge clk);
    #1 cmd_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s3_alu_stable", {alu_opcode3, alu_a3, alu_b3}, {OpAnd, 4'hC, 4'hA});
      check("s3_not_yet", rsp_valid3, 0);
    end
    @(negedge clk);
    check("s3_valid", rsp_valid3, 1);
    check("s3_y", rsp_y3, 4'h8);
    check("s3_flags", rsp_flags3, 4'b1000);
    rsp_ready3 = 1'b1;
    @(posedge clk);
    #1 rsp_ready3 = 1'b0;
    @(negedge clk);
    check("s3_idle", cmd_ready3, 1);

`ifdef ALU_CTRL_ILLEGAL_OP_EN
    issue(OpAdd, 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 4'b0110, 1'b0);
    collect(1);
    @(negedge clk);
    cmd_opcode = 4'hC; cmd_a = 4'h5; cmd_b = 4'h5; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("ill_valid", rsp_valid, 1);
    check("ill_err", rsp_err, 1);
    check("ill_y", {rsp_y, rsp_flags}, 0);
    check("ill_flags_kept", flags, 4'b0110);
    check("ill_alu_kept", {alu_opcode, alu_a, alu_b}, {OpAdd, 4'hF, 4'h1});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue(OpAdd, 4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 4'b1001, 1'b0);
    collect(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
